// File: rtl/fb_pixel_writer.sv
// Queues rasterizer pixel addresses and drains them to the frame-buffer SRAM over a req/ack handshake.
// Latency: a push into an empty idle FIFO reaches sram_we two edges later. Backpressure: registered stop with SLACK entries in hand.
module fb_pixel_writer #(
  parameter int ADDR_W   = 19,
  parameter int COLOR_W  = 8,
  parameter int DEPTH    = 8,
  parameter int SLACK    = 2,
  parameter int MAX_ADDR = 307199
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_valid,
  input  logic [ADDR_W-1:0]  pix_addr,
  input  logic [COLOR_W-1:0] pix_color,
  input  logic               prim_done,
  output logic               stop,
  output logic               sram_we,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [COLOR_W-1:0] sram_data,
  input  logic               sram_ack,
  output logic               frame_done,
  output logic               busy,
  output logic               overflow,
  output logic               oob_drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  STOP_CNT = CNT_W'(DEPTH - SLACK);
  localparam logic [ADDR_W-1:0] MAX_A    = ADDR_W'(MAX_ADDR);

  typedef enum logic {IDLE, WRITE} state_t;

  typedef struct packed {
    logic [COLOR_W-1:0] color;
    logic [ADDR_W-1:0]  addr;
  } pix_t;

  state_t             state, state_nxt;
  pix_t               mem [DEPTH];
  pix_t               head;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, count_nxt;
  logic               fifo_ne, in_range, push, pop;
  logic               oob_hit, ovf_hit, fire;
  logic               pending_done;

  assign fifo_ne  = (count != '0);
  assign in_range = (pix_addr <= MAX_A);
  assign head     = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign push    = pix_valid && in_range && ((count < FULL_CNT) || pop);
  assign oob_hit = pix_valid && !in_range;
  assign ovf_hit = pix_valid && in_range && !push;
  assign fire    = pending_done && !fifo_ne && (state == IDLE) && !push;
  assign busy    = fifo_ne || (state == WRITE) || pending_done;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fifo_ne) state_nxt = WRITE;
      WRITE:   if (sram_ack && !fifo_ne) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop     = 1'b0;
    sram_we = 1'b0;
    case (state)
      IDLE:    pop = fifo_ne;
      WRITE: begin
        sram_we = 1'b1;
        pop     = fifo_ne && sram_ack;
      end
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{color: pix_color, addr: pix_addr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      stop         <= 1'b0;
      sram_addr    <= '0;
      sram_data    <= '0;
      pending_done <= 1'b0;
      frame_done   <= 1'b0;
      overflow     <= 1'b0;
      oob_drop     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        sram_addr <= head.addr;
        sram_data <= head.color;
      end
      count        <= count_nxt;
      stop         <= (count_nxt >= STOP_CNT);
      frame_done   <= fire;
      // A new prim_done in the firing cycle belongs to the next primitive, so it wins.
      pending_done <= (pending_done && !fire) || prim_done;
      if (ovf_hit) overflow <= 1'b1;
      if (oob_hit) oob_drop <= 1'b1;
    end
  end

endmodule
